prio_encoder_serial: RTL
========================

// Module: prio_encoder_serial
// PURPOSE
//  Parametrised successor to the team's 8:3 priority encoder. Accepts an N-bit request vector
//  over a valid/ready handshake, latches it, then emits each set bit as a binary index, one per
//  output handshake, highest priority first. Sits between request sources (IRQ lines, channel
//  requests) and a single-issue consumer that services one index at a time.
// PARAMETERS
//  N   8              number of request lines (>= 2)
//  W   $clog2(N)      index width (derived; do not override)
// PORTS
//  clk           in   1  clock, all state updates on rising edge
//  rst           in   1  synchronous, active-high reset
//  req_valid     in   1  request vector valid
//  req_ready     out  1  block can accept a vector
//  req           in   N  request vector, bit i = line i requesting
//  grant_valid   out  1  grant_idx/grant_onehot valid
//  grant_ready   in   1  consumer accepts current grant
//  grant_idx     out  W  index of granted line
//  grant_onehot  out  N  one-hot of granted line (1 << grant_idx)
//  pending       out  N  bits still to be granted (pend register)
// BEHAVIOUR
//  - Single clock clk; rst is synchronous, active-high. On rst: state=IDLE, pend=0, rr_last=0;
//    while rst high req_ready=0, grant_valid=0, grant_idx=0, grant_onehot=0, pending=0.
//  - FSM states (state_t): IDLE, SCAN.
//  - IDLE: req_ready=1, grant_valid=0, grant_idx=0, grant_onehot=0.
//    req_valid && req!=0 -> pend<=req, ->SCAN. req_valid && req==0 -> vector consumed, dropped, stay IDLE.
//  - SCAN: req_ready=0, grant_valid=1; grant_idx = selected bit of pend (see priority below).
//    grant_valid && grant_ready -> clear selected bit in pend; if pend becomes 0 -> IDLE, else stay.
//    grant_valid && !grant_ready -> pend, grant_idx, grant_onehot held stable (no change).
//  - Latency: vector accepted at edge k -> grant_valid=1 in cycle k+1. Throughput: one grant per
//    cycle while grant_ready held high. One bubble cycle (IDLE) between consecutive vectors.
//  - Fixed priority: highest set index wins (bit N-1 highest, bit 0 lowest), as the 8:3 encoder.
//  - grant outputs are decoded combinationally from registered pend (and rr_last); no comb path
//    from req or grant_ready to grant_idx/grant_onehot/grant_valid.
//  - grant_ready in IDLE ignored; req_valid in SCAN ignored (not consumed, req_ready=0).
//  - rst asserted mid-SCAN: remaining pend bits discarded, next cycle IDLE.
// CONFIGURATION
//  ROUND_ROBIN_EN defined: register rr_last [W-1:0] (reset 0) holds last granted index, persists
//   across vectors. Search order rr_last-1, rr_last-2, ... wrapping through N-1 down to rr_last;
//   first set bit in pend wins. On each grant handshake rr_last<=grant_idx. With rr_last=0 the
//   order equals fixed priority. Not updated on rst-cleared or dropped vectors.
//  ROUND_ROBIN_EN undefined: fixed priority only; no rr_last register.
// STRUCTURE
//  - prio_enc_pkg: state_t enum {IDLE, SCAN}; RR_LAST_RST constant (0).
//  - Sub-module prio_find #(N): combinational, in vec[N-1:0] -> out idx[W-1:0], found;
//    highest-set-bit search. Round-robin implemented by rotating pend by rr_last before
//    prio_find and un-rotating the index after.
// TESTING
//  1 Reset: rst=1 two cycles -> req_ready=0, grant_valid=0, pending=0; release -> req_ready=1.
//  2 N=8, req=8'b1010_0101, grant_ready=1 -> grant_idx 7,5,2,0 on 4 consecutive cycles, then IDLE.
//  3 Backpressure: req=8'b0001_1000, grant_ready=0 for 3 cycles -> grant_idx=4 held stable,
//    pending=8'b0001_1000; then ready=1 -> 4 then 3.
//  4 req_valid with req=0 -> consumed, grant_valid stays 0, req_ready stays 1.
//  5 rst pulsed while pending=8'b0000_0110 -> next cycle IDLE, pending=0, grant_valid=0.
//  6 ROUND_ROBIN_EN: req=8'hFF, grant 7 only, then rst-free new vector flow: after grant 7
//    rr_last=7; next vector 8'b1000_0001 -> grant 0 before 7.

Source files
------------

// File: rtl/prio_enc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : prio_enc_pkg
// Brief   : Shared types and constants for the serial priority encoder.
// Revision: 1.0 - initial release
// ============================================================================
package prio_enc_pkg;

    // Controller states: waiting for a vector, or issuing its grants
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Reset value of the round-robin last-grant pointer
    localparam int RR_LAST_RST = 0;

endpackage
`default_nettype wire

// File: rtl/prio_find.sv
`default_nettype none
// ============================================================================
// Module  : prio_find
// Brief   : Combinational highest-set-bit search over an N-bit vector.
//           idx is meaningful only when found is high, and is 0 otherwise.
// Revision: 1.0 - initial release
// ============================================================================
module prio_find #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         found
);

    // Ascending scan: the last set bit seen is the highest one
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/prio_encoder_serial.sv
`default_nettype none
// ============================================================================
// Module  : prio_encoder_serial
// Brief   : Latches an N-bit request vector over a valid/ready handshake and
//           issues one grant index per output handshake, highest index first.
//           Optional macro ROUND_ROBIN_EN: search starts below the previously
//           granted index and wraps, using a persistent rr_last pointer.
// Revision: 1.0 - initial release
// ============================================================================
module prio_encoder_serial
    import prio_enc_pkg::*;
#(
    parameter int N = 8,
    // Derived from N; leave at its default
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req,
    output logic         grant_valid,
    input  logic         grant_ready,
    output logic [W-1:0] grant_idx,
    output logic [N-1:0] grant_onehot,
    output logic [N-1:0] pending
);

    state_t         state_q, state_d;
    logic [N-1:0]   pend_q, pend_d;
    logic [N-1:0]   search_vec;
    logic [W-1:0]   find_idx;
    logic           find_hit;
    logic [W-1:0]   sel_idx;
    logic [N-1:0]   sel_onehot;

`ifdef ROUND_ROBIN_EN
    logic [W-1:0]   rr_last_q, rr_last_d;

    // Rotate pend right by rr_last so the highest search position maps to
    // rr_last-1, then map the found position back to a real line index
    always_comb begin
        int         s;
        logic [W-1:0] pos;
        s          = 0;
        pos        = '0;
        search_vec = '0;
        for (int j = 0; j < N; j++) begin
            s = int'(rr_last_q) + j;
            if (s >= N) s = s - N;
            pos = W'(s);
            search_vec[j] = pend_q[pos];
        end
        s = int'(rr_last_q) + int'(find_idx);
        if (s >= N) s = s - N;
        sel_idx = W'(s);
    end
`else
    assign search_vec = pend_q;
    assign sel_idx    = find_idx;
`endif

    prio_find #(.N(N), .W(W)) u_find (
        .vec   (search_vec),
        .idx   (find_idx),
        .found (find_hit)
    );

    assign sel_onehot = {{(N-1){1'b0}}, 1'b1} << sel_idx;

    // Next-state, pend update and handshake outputs; rst forces outputs idle
    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
`ifdef ROUND_ROBIN_EN
        rr_last_d    = rr_last_q;
`endif
        req_ready    = 1'b0;
        grant_valid  = 1'b0;
        grant_idx    = '0;
        grant_onehot = '0;
        pending      = pend_q;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                // An all-zero vector is consumed and dropped
                if (req_valid && (req != '0)) begin
                    pend_d  = req;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                grant_valid  = find_hit;
                grant_idx    = sel_idx;
                grant_onehot = sel_onehot;
                if (grant_ready) begin
                    pend_d = pend_q & ~sel_onehot;
`ifdef ROUND_ROBIN_EN
                    rr_last_d = sel_idx;
`endif
                    if (pend_d == '0) state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                pend_d  = '0;
            end
        endcase
        if (rst) begin
            req_ready    = 1'b0;
            grant_valid  = 1'b0;
            grant_idx    = '0;
            grant_onehot = '0;
            pending      = '0;
        end
    end

    // State, pend and round-robin pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pend_q    <= '0;
`ifdef ROUND_ROBIN_EN
            rr_last_q <= W'(RR_LAST_RST);
`endif
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
`ifdef ROUND_ROBIN_EN
            rr_last_q <= rr_last_d;
`endif
        end
    end

endmodule
`default_nettype wire
